// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: direction counter encodings,
// reset/allocation values and table sizing helpers.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;
  localparam ctr_t CTR_ALLOC = WT;

  function automatic int idx_width(input int entries);
    return $clog2(entries);
  endfunction

  // Saturating 2-bit direction counter step.
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    case (c)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      ST:      n = taken ? ST  : WT;
      default: n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module bp_sat_ctr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Branch target buffer with 2-bit direction counters: combinational IF-stage
// lookup, EX-stage update with mispredict redirect, and hit/miss statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  lk_pc,
  output logic             lk_hit,
  output logic             lk_taken,
  output logic [PC_W-1:0]  lk_next_pc,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [PC_W-1:0]  upd_target,
  input  logic [PC_W-1:0]  upd_pred_next_pc,
  input  logic             stall,
  input  logic             flush_all,
  output logic             mispredict,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = idx_width(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tags    [ENTRIES];
  logic [PC_W-1:0]    targets [ENTRIES];
  ctr_t               ctrs    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_hit, upd_fire;
  logic [PC_W-1:0]  actual_next;
  logic             unused_pc_bits;

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[PC_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[PC_W-1:IDX_W+2];

  // Instructions are word aligned, so the low PC bits never select anything.
  assign unused_pc_bits = ^{lk_pc[1:0], upd_pc[1:0]};

  assign lk_hit     = valid[lk_idx] && (tags[lk_idx] == lk_tag);
  assign lk_taken   = lk_hit && ctrs[lk_idx][1];
  assign lk_next_pc = lk_taken ? targets[lk_idx] : lk_pc + PC_W'(4);

  assign upd_fire    = upd_valid && !stall;
  assign upd_hit     = valid[upd_idx] && (tags[upd_idx] == upd_tag);
  assign actual_next = upd_taken ? upd_target : upd_pc + PC_W'(4);
  assign mispredict  = upd_fire && (upd_pred_next_pc != actual_next);
  assign redirect_pc = actual_next;

  // Flush beats a coincident update; not-taken misses never allocate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tags[i]    <= '0;
        targets[i] <= '0;
        ctrs[i]    <= CTR_RESET;
      end
    end else if (flush_all) begin
      valid <= '0;
    end else if (upd_fire) begin
      if (upd_hit) begin
        ctrs[upd_idx] <= ctr_next(ctrs[upd_idx], upd_taken);
        if (upd_taken) begin
          targets[upd_idx] <= upd_target;
        end
      end else if (upd_taken) begin
        valid[upd_idx]   <= 1'b1;
        tags[upd_idx]    <= upd_tag;
        targets[upd_idx] <= upd_target;
        ctrs[upd_idx]    <= CTR_ALLOC;
      end
    end
  end

  bp_sat_ctr #(.W(CNT_W)) u_stat_branches (
    .clk   (clk),
    .reset (reset),
    .en    (upd_fire),
    .count (stat_branches)
  );

  bp_sat_ctr #(.W(CNT_W)) u_stat_mispredicts (
    .clk   (clk),
    .reset (reset),
    .en    (mispredict),
    .count (stat_mispredicts)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized bench for branch_predictor against an array-based model of the
// predictor, plus directed scenarios with hand-computed expectations.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lk_pc;
  logic        lk_hit, lk_taken;
  logic [31:0] lk_next_pc;
  logic        upd_valid, upd_taken, stall, flush_all;
  logic [31:0] upd_pc, upd_target, upd_pred_next_pc;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [15:0] stat_branches, stat_mispredicts;

  logic        lk_hit4, lk_taken4, mispredict4;
  logic [31:0] lk_next_pc4, redirect_pc4;
  logic [3:0]  stat_branches4, stat_mispredicts4;

  int n_vectors = 0;
  int n_miscompares = 0;

  bit          m_valid  [16];
  logic [31:0] m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];
  int          m_br, m_mp, m_br4, m_mp4;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(16), .PC_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken),
    .lk_next_pc(lk_next_pc), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_next_pc(upd_pred_next_pc), .stall(stall),
    .flush_all(flush_all), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  branch_predictor #(.ENTRIES(16), .PC_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .lk_pc(lk_pc), .lk_hit(lk_hit4), .lk_taken(lk_taken4),
    .lk_next_pc(lk_next_pc4), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_next_pc(upd_pred_next_pc), .stall(stall),
    .flush_all(flush_all), .mispredict(mispredict4), .redirect_pc(redirect_pc4),
    .stat_branches(stat_branches4), .stat_mispredicts(stat_mispredicts4)
  );

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == (pc >> 6));
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] pc);
    return m_taken(pc) ? m_target[m_idx(pc)] : pc + 32'd4;
  endfunction

  function automatic logic [31:0] m_actual();
    return upd_taken ? upd_target : upd_pc + 32'd4;
  endfunction

  function automatic bit m_mispredict();
    return upd_valid && !stall && (upd_pred_next_pc != m_actual());
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] lk, input logic v, input logic [31:0] pc,
                               input logic tk, input logic [31:0] tgt, input logic [31:0] pred,
                               input logic st, input logic fl);
    lk_pc = lk; upd_valid = v; upd_pc = pc; upd_taken = tk;
    upd_target = tgt; upd_pred_next_pc = pred; stall = st; flush_all = fl;
  endtask

  task automatic checkStats(input int br, input int mp);
    checkOutput("stat_branches", 32'(stat_branches), br);
    checkOutput("stat_mispredicts", 32'(stat_mispredicts), mp);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Model state evolves on the same edges as the DUT, from the rules of operation.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 1'b0; m_tag[i] = '0; m_target[i] = '0; m_ctr[i] = 1;
      end
      m_br = 0; m_mp = 0; m_br4 = 0; m_mp4 = 0;
    end else begin
      if (upd_valid && !stall) begin
        if (m_br < 65535) m_br++;
        if (m_br4 < 15) m_br4++;
        if (m_mispredict()) begin
          if (m_mp < 65535) m_mp++;
          if (m_mp4 < 15) m_mp4++;
        end
      end
      if (flush_all) begin
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      end else if (upd_valid && !stall) begin
        if (m_hit(upd_pc)) begin
          if (upd_taken) begin
            m_ctr[m_idx(upd_pc)] = (m_ctr[m_idx(upd_pc)] == 3) ? 3 : m_ctr[m_idx(upd_pc)] + 1;
            m_target[m_idx(upd_pc)] = upd_target;
          end else begin
            m_ctr[m_idx(upd_pc)] = (m_ctr[m_idx(upd_pc)] == 0) ? 0 : m_ctr[m_idx(upd_pc)] - 1;
          end
        end else if (upd_taken) begin
          m_valid[m_idx(upd_pc)]  = 1'b1;
          m_tag[m_idx(upd_pc)]    = upd_pc >> 6;
          m_target[m_idx(upd_pc)] = upd_target;
          m_ctr[m_idx(upd_pc)]    = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("lk_hit", 32'(lk_hit), 32'(m_hit(lk_pc)));
    checkOutput("lk_taken", 32'(lk_taken), 32'(m_taken(lk_pc)));
    checkOutput("lk_next_pc", lk_next_pc, m_next(lk_pc));
    checkOutput("mispredict", 32'(mispredict), 32'(m_mispredict()));
    checkOutput("redirect_pc", redirect_pc, m_actual());
    checkOutput("stat_branches", 32'(stat_branches), m_br);
    checkOutput("stat_mispredicts", 32'(stat_mispredicts), m_mp);
    checkOutput("stat_branches4", 32'(stat_branches4), m_br4);
    checkOutput("stat_mispredicts4", 32'(stat_mispredicts4), m_mp4);
  end

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin
    reset = 1'b0;
    applyStimulus(32'h40, 0, 0, 0, 0, 0, 0, 0);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    checkOutput("rst_hit", 32'(lk_hit), 0);
    checkOutput("rst_taken", 32'(lk_taken), 0);
    checkOutput("rst_next", lk_next_pc, 32'h44);
    checkStats(0, 0);
    nextCycle();

    applyStimulus(32'h100, 1, 32'h100, 1, 32'h200, 32'h104, 0, 0);
    @(negedge clk);
    checkOutput("alloc_mispredict", 32'(mispredict), 1);
    checkOutput("alloc_redirect", redirect_pc, 32'h200);
    checkOutput("no_bypass_hit", 32'(lk_hit), 0);
    nextCycle();

    applyStimulus(32'h100, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("after_alloc_hit", 32'(lk_hit), 1);
    checkOutput("after_alloc_taken", 32'(lk_taken), 1);
    checkOutput("after_alloc_next", lk_next_pc, 32'h200);
    checkStats(1, 1);
    nextCycle();

    repeat (3) begin
      applyStimulus(32'h100, 1, 32'h100, 1, 32'h200, 32'h200, 0, 0);
      @(negedge clk);
      checkOutput("taken_correct_mispredict", 32'(mispredict), 0);
      nextCycle();
    end

    applyStimulus(32'h100, 1, 32'h100, 0, 32'h200, 32'h200, 0, 0);
    @(negedge clk);
    checkOutput("nt1_mispredict", 32'(mispredict), 1);
    checkOutput("nt1_redirect", redirect_pc, 32'h104);
    nextCycle();
    applyStimulus(32'h100, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("from_st_still_taken", 32'(lk_taken), 1);
    checkStats(5, 2);
    nextCycle();

    applyStimulus(32'h100, 1, 32'h100, 0, 32'h200, 32'h200, 0, 0);
    nextCycle();
    applyStimulus(32'h100, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("wnt_hit", 32'(lk_hit), 1);
    checkOutput("wnt_taken", 32'(lk_taken), 0);
    checkOutput("wnt_next", lk_next_pc, 32'h104);
    nextCycle();

    applyStimulus(32'h100, 1, 32'h140, 1, 32'h300, 32'h144, 0, 0);
    nextCycle();
    applyStimulus(32'h100, 1, 32'h180, 0, 32'h999, 32'h184, 0, 0);
    @(negedge clk);
    checkOutput("alias_old_miss", 32'(lk_hit), 0);
    checkOutput("nt_miss_mispredict", 32'(mispredict), 0);
    nextCycle();
    applyStimulus(32'h140, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("alias_new_next", lk_next_pc, 32'h300);
    checkStats(8, 4);
    nextCycle();

    repeat (3) begin
      applyStimulus(32'h140, 1, 32'h180, 1, 32'h400, 32'h184, 1, 0);
      @(negedge clk);
      checkOutput("stall_mispredict", 32'(mispredict), 0);
      checkOutput("stall_table", lk_next_pc, 32'h300);
      checkStats(8, 4);
      nextCycle();
    end
    applyStimulus(32'h140, 1, 32'h180, 1, 32'h400, 32'h184, 0, 0);
    @(negedge clk);
    checkOutput("release_mispredict", 32'(mispredict), 1);
    nextCycle();
    applyStimulus(32'h180, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("release_next", lk_next_pc, 32'h400);
    checkStats(9, 5);
    nextCycle();

    applyStimulus(32'h180, 1, 32'h100, 1, 32'h200, 32'h104, 0, 1);
    nextCycle();
    applyStimulus(32'h180, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("flush_hit", 32'(lk_hit), 0);
    checkOutput("flush_next", lk_next_pc, 32'h184);
    checkStats(10, 6);
    nextCycle();
    applyStimulus(32'h100, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("flush_dropped_write", 32'(lk_hit), 0);
    nextCycle();

    applyStimulus(32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("wrap_next", lk_next_pc, 32'h0);
    nextCycle();

    for (int c = 0; c < 1500; c++) begin
      logic [31:0] p;
      reset = ($urandom_range(0, 199) == 0);
      p = rand_pc();
      lk_pc = rand_pc();
      upd_valid = ($urandom_range(0, 99) < 70);
      upd_pc = p;
      upd_taken = $urandom_range(0, 1);
      upd_target = 32'($urandom_range(0, 255)) << 2;
      case ($urandom_range(0, 2))
        0: upd_pred_next_pc = m_next(p);
        1: upd_pred_next_pc = p + 32'd4;
        default: upd_pred_next_pc = upd_target;
      endcase
      stall = ($urandom_range(0, 99) < 15);
      flush_all = ($urandom_range(0, 99) < 3);
      nextCycle();
    end

    reset = 1'b1;
    applyStimulus(32'h0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    reset = 1'b0;
    repeat (20) begin
      applyStimulus(32'h0, 1, 32'h20, 1, 32'h80, 32'h80, 0, 0);
      nextCycle();
    end
    applyStimulus(32'h0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("sat4_branches", 32'(stat_branches4), 15);
    checkOutput("wide_branches", 32'(stat_branches), 20);

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
